// File: rtl/gpio_debounce.sv
// Per-pin input conditioner: a 2-flop synchroniser followed by a stability filter with programmable threshold.
// Optional registered rise/fall pulses are built only when GPIO_DEBOUNCE_EDGE_EN is defined.
module gpio_debounce #(
    parameter int NUM_PINS = 6,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] pad_in,
    input  logic [CNT_W-1:0]    db_threshold,
    input  logic [NUM_PINS-1:0] db_bypass,
    output logic [NUM_PINS-1:0] pin_out,
    output logic [NUM_PINS-1:0] pin_rise,
    output logic [NUM_PINS-1:0] pin_fall
);

    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W-1:0] thr_last;

    // A zero threshold behaves as one so that filtering never blocks acceptance.
    assign thr_eff  = (db_threshold == '0) ? CNT_W'(1) : db_threshold;
    assign thr_last = thr_eff - CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             stable_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            always_comb begin
                stable_next = stable_reg;
                cnt_next    = '0;
                if (db_bypass[gi]) begin
                    stable_next = sync2_reg;
                end else if (sync2_reg != stable_reg) begin
                    // ">=" lets a lowered threshold release a long pending level immediately.
                    if (cnt_reg >= thr_last) begin
                        stable_next = sync2_reg;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg  <= pad_in[gi];
                    sync2_reg  <= sync1_reg;
                    stable_reg <= stable_next;
                    cnt_reg    <= cnt_next;
                end
            end

            assign pin_out[gi] = stable_reg;

`ifdef GPIO_DEBOUNCE_EDGE_EN
            logic prev_reg;
            logic rise_reg;
            logic fall_reg;

            // Pulses appear the cycle after pin_out changes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_reg <= 1'b0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    prev_reg <= stable_reg;
                    rise_reg <= stable_reg & ~prev_reg;
                    fall_reg <= ~stable_reg & prev_reg;
                end
            end

            assign pin_rise[gi] = rise_reg;
            assign pin_fall[gi] = fall_reg;
`else
            assign pin_rise[gi] = 1'b0;
            assign pin_fall[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_gpio_debounce.sv
// Self-checking bench for gpio_debounce: a cycle model feeds an expected-value queue, plus directed latency checks.
// Edge-pulse expectations follow GPIO_DEBOUNCE_EDGE_EN.
module tb_gpio_debounce;

    localparam int NUM_PINS = 6;
    localparam int CNT_W    = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_PINS-1:0] pad_in;
    logic [CNT_W-1:0]    db_threshold;
    logic [NUM_PINS-1:0] db_bypass;
    logic [NUM_PINS-1:0] pin_out;
    logic [NUM_PINS-1:0] pin_rise;
    logic [NUM_PINS-1:0] pin_fall;

    gpio_debounce #(.NUM_PINS(NUM_PINS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pad_in      (pad_in),
        .db_threshold(db_threshold),
        .db_bypass   (db_bypass),
        .pin_out     (pin_out),
        .pin_rise    (pin_rise),
        .pin_fall    (pin_fall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_PINS-1:0] out;
        logic [NUM_PINS-1:0] rise;
        logic [NUM_PINS-1:0] fall;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: "age" counts pending edges of a differing level, accepting when it reaches thr.
    logic [NUM_PINS-1:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_prev = '0, m_rise = '0, m_fall = '0;
    int m_age[NUM_PINS];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int thr;
        logic old_st;
        thr = (db_threshold == 0) ? 1 : int'(db_threshold);
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_prev = '0; m_rise = '0; m_fall = '0;
            for (int p = 0; p < NUM_PINS; p++) m_age[p] = 0;
        end else begin
            for (int p = 0; p < NUM_PINS; p++) begin
                old_st = m_st[p];
                if (db_bypass[p]) begin
                    m_st[p] = m_s2[p];
                    m_age[p] = 0;
                end else if (m_s2[p] == m_st[p]) begin
                    m_age[p] = 0;
                end else begin
                    m_age[p]++;
                    if (m_age[p] >= thr) begin
                        m_st[p] = m_s2[p];
                        m_age[p] = 0;
                    end
                end
`ifdef GPIO_DEBOUNCE_EDGE_EN
                m_rise[p] = old_st & ~m_prev[p];
                m_fall[p] = ~old_st & m_prev[p];
`else
                m_rise[p] = 1'b0;
                m_fall[p] = 1'b0;
`endif
                m_prev[p] = old_st;
            end
            m_s2 = m_s1;
            m_s1 = pad_in;
        end
    endtask

    // One clock: model predicts, the prediction is queued, then compared once the DUT has settled.
    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        exp_q.push_back('{out: m_st, rise: m_rise, fall: m_fall});
        #1;
        e = exp_q.pop_front();
        check_value("pin_out",  32'(pin_out),  32'(e.out));
        check_value("pin_rise", 32'(pin_rise), 32'(e.rise));
        check_value("pin_fall", 32'(pin_fall), 32'(e.fall));
    endtask

    task automatic wait_level(input int pin, input logic lvl, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (pin_out[pin] !== lvl && n <= max);
    endtask

    task automatic wait_mask(input logic [NUM_PINS-1:0] want, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (pin_out !== want && n <= max);
    endtask

    initial begin
        int n;
        for (int p = 0; p < NUM_PINS; p++) m_age[p] = 0;
        rst = 1'b1; pad_in = '1; db_threshold = 16'd4; db_bypass = '0;

        repeat (3) step();
        check_value("rst_out", 32'(pin_out), 32'h0);
        check_value("rst_edges", 32'(pin_rise | pin_fall), 32'h0);

        rst = 1'b0;
        wait_mask('1, 20, n);
        check_value("rst_release_lat", n, 6);

        pad_in = '0;
        wait_mask('0, 20, n);
        check_value("fall_all_lat", n, 6);

        // Clean rising edge on pin 0
        db_threshold = 16'd10;
        pad_in[0] = 1'b1;
        wait_level(0, 1'b1, 30, n);
        check_value("clean_edge_lat", n, 12);
        check_value("rise_not_yet", 32'(pin_rise[0]), 32'h0);
        step();
`ifdef GPIO_DEBOUNCE_EDGE_EN
        check_value("rise_pulse", 32'(pin_rise[0]), 32'h1);
`else
        check_value("rise_tied", 32'(pin_rise[0]), 32'h0);
`endif
        step();
        check_value("rise_one_cycle", 32'(pin_rise[0]), 32'h0);

        // Glitch rejection on pin 2
        pad_in[2] = 1'b1;
        repeat (9) step();
        pad_in[2] = 1'b0;
        step();
        check_value("glitch_held", 32'(pin_out[2]), 32'h0);
        pad_in[2] = 1'b1;
        wait_level(2, 1'b1, 30, n);
        check_value("glitch_run_lat", n, 12);

        // Zero threshold acts as one
        db_threshold = 16'd0;
        pad_in[3] = 1'b1;
        wait_level(3, 1'b1, 10, n);
        check_value("thr0_lat", n, 3);

        // Lowering threshold mid-count releases on the next edge
        db_threshold = 16'd100;
        pad_in[4] = 1'b1;
        repeat (52) step();
        check_value("thr_low_pending", 32'(pin_out[4]), 32'h0);
        db_threshold = 16'd20;
        step();
        check_value("thr_low_accept", 32'(pin_out[4]), 32'h1);

        // Bypass on pin 1
        db_threshold = 16'd10;
        db_bypass[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pad_in[1] = ~pad_in[1];
            step();
            step();
        end
        pad_in[1] = 1'b0;
        repeat (4) step();
        pad_in[1] = 1'b1;
        wait_level(1, 1'b1, 10, n);
        check_value("bypass_lat", n, 3);
        db_bypass[1] = 1'b0;
        pad_in[1] = 1'b0;
        wait_level(1, 1'b0, 30, n);
        check_value("unbypass_lat", n, 12);

        // Reset in the middle of qualification
        db_threshold = 16'd4;
        pad_in = '0;
        repeat (8) step();
        check_value("settle_low", 32'(pin_out), 32'h0);
        db_threshold = 16'd8;
        pad_in = '1;
        repeat (5) step();
        rst = 1'b1;
        step();
        check_value("rst_mid_out", 32'(pin_out), 32'h0);
        rst = 1'b0;
        wait_mask('1, 20, n);
        check_value("rst_mid_lat", n, 10);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) begin
                db_threshold = 16'($urandom_range(0, 6));
                db_bypass    = NUM_PINS'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 3) == 0)
                pad_in[$urandom_range(0, NUM_PINS - 1)] ^= 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
